// File: rtl/fifo_uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : fifo_uart_tx
// Description : Drains bytes from a FIFO read port and sends each one as an
//               asynchronous serial frame: start bit, data LSB first,
//               optional even parity, STOP_BITS stop bits.
// Ports       : clk    - clock, all state changes on posedge
//               rst    - asynchronous reset, active-high
//               en     - 1 = a new frame may start (a running frame always ends)
//               empty  - FIFO empty flag
//               datain - FIFO read data, valid while FIFO not empty
//               pop    - FIFO pop, one cycle per frame, from registered state
//               tx     - serial line, idle high, registered
//               busy   - high from FETCH through the last stop bit
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_uart_tx #(
    parameter int WIDTH        = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             empty,
    input  logic [WIDTH-1:0] datain,
    output logic             pop,
    output logic             tx,
    output logic             busy
);

    localparam int c_TMR_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    // bit_idx is 0 at the first data bit and reaches c_LAST_BIT on the final stop bit
    localparam int c_LAST_BIT = WIDTH + PARITY + STOP_BITS - 1;
    localparam int c_IDX_W    = $clog2(c_LAST_BIT + 1);

    localparam logic [c_TMR_W-1:0] c_TMR_LAST  = c_TMR_W'(CLKS_PER_BIT - 1);
    localparam logic [c_TMR_W-1:0] c_TMR_ZERO  = '0;
    localparam logic [c_TMR_W-1:0] c_TMR_ONE   = c_TMR_W'(1);
    localparam logic [c_IDX_W-1:0] c_IDX_ZERO  = '0;
    localparam logic [c_IDX_W-1:0] c_IDX_ONE   = c_IDX_W'(1);
    localparam logic [c_IDX_W-1:0] c_IDX_DLAST = c_IDX_W'(WIDTH - 1);
    localparam logic [c_IDX_W-1:0] c_IDX_LAST  = c_IDX_W'(c_LAST_BIT);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_START  = 3'd2,
        S_DATA   = 3'd3,
        S_PARITY = 3'd4,
        S_STOP   = 3'd5
    } state_t;

    state_t             r_state, w_state_next;
    logic               r_avail, w_avail_next;
    logic [c_TMR_W-1:0] r_tmr,   w_tmr_next;
    logic [c_IDX_W-1:0] r_idx,   w_idx_next;
    logic [WIDTH-1:0]   r_shreg, w_shreg_next;
    logic               r_par,   w_par_next;
    logic               r_tx,    w_tx_next;
    logic               w_bit_end;

    assign w_bit_end = (r_tmr == c_TMR_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_avail <= 1'b0;
            r_tmr   <= c_TMR_ZERO;
            r_idx   <= c_IDX_ZERO;
            r_shreg <= '0;
            r_par   <= 1'b0;
            r_tx    <= 1'b1;
        end else begin
            r_state <= w_state_next;
            r_avail <= w_avail_next;
            r_tmr   <= w_tmr_next;
            r_idx   <= w_idx_next;
            r_shreg <= w_shreg_next;
            r_par   <= w_par_next;
            r_tx    <= w_tx_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_tmr_next   = r_tmr;
        w_idx_next   = r_idx;
        w_shreg_next = r_shreg;
        w_par_next   = r_par;

        case (r_state)
            S_IDLE: begin
                w_tmr_next = c_TMR_ZERO;
                w_idx_next = c_IDX_ZERO;
                if (r_avail && en) begin
                    w_state_next = S_FETCH;
                end
            end
            S_FETCH: begin
                w_shreg_next = datain;
                w_par_next   = ^datain;
                w_tmr_next   = c_TMR_ZERO;
                w_state_next = S_START;
            end
            S_START: begin
                if (w_bit_end) begin
                    w_tmr_next   = c_TMR_ZERO;
                    w_idx_next   = c_IDX_ZERO;
                    w_state_next = S_DATA;
                end else begin
                    w_tmr_next = r_tmr + c_TMR_ONE;
                end
            end
            S_DATA: begin
                if (w_bit_end) begin
                    w_tmr_next   = c_TMR_ZERO;
                    w_shreg_next = {1'b0, r_shreg[WIDTH-1:1]};
                    w_idx_next   = r_idx + c_IDX_ONE;
                    if (r_idx == c_IDX_DLAST) begin
                        w_state_next = (PARITY != 0) ? S_PARITY : S_STOP;
                    end
                end else begin
                    w_tmr_next = r_tmr + c_TMR_ONE;
                end
            end
            S_PARITY: begin
                if (w_bit_end) begin
                    w_tmr_next   = c_TMR_ZERO;
                    w_idx_next   = r_idx + c_IDX_ONE;
                    w_state_next = S_STOP;
                end else begin
                    w_tmr_next = r_tmr + c_TMR_ONE;
                end
            end
            S_STOP: begin
                if (w_bit_end) begin
                    w_tmr_next = c_TMR_ZERO;
                    if (r_idx == c_IDX_LAST) begin
                        w_state_next = S_IDLE;
                    end else begin
                        w_idx_next = r_idx + c_IDX_ONE;
                    end
                end else begin
                    w_tmr_next = r_tmr + c_TMR_ONE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Availability is sampled on every cycle whose successor is IDLE, including
    // the final stop cycle, so a waiting byte is already flagged on the first
    // IDLE cycle and back-to-back frames are separated by IDLE + FETCH only.
    // pop is never high in those cycles, so empty is not in a loop with pop.
    assign w_avail_next = (w_state_next == S_IDLE) ? ~empty : 1'b0;

    // tx is computed from the next state so the output register changes
    // exactly on bit boundaries.
    always_comb begin
        w_tx_next = 1'b1;
        case (w_state_next)
            S_START:  w_tx_next = 1'b0;
            S_DATA:   w_tx_next = w_shreg_next[0];
            S_PARITY: w_tx_next = w_par_next;
            default:  w_tx_next = 1'b1;
        endcase
    end

    assign pop  = (r_state == S_FETCH);
    assign busy = (r_state != S_IDLE);
    assign tx   = r_tx;

endmodule
`default_nettype wire

// File: tb/tb_fifo_uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_uart_tx
// Description : Bench for fifo_uart_tx. dut0 (no parity, 1 stop) is fed by a
//               depth-4 FIFO model; dut1 (even parity, 2 stops) is fed by a
//               one-entry mailbox. CLKS_PER_BIT = 4 for both.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_uart_tx;

    localparam int c_CPB = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       empty0, pop0, tx0, busy0;
    logic [7:0] din0;
    logic       empty1, pop1, tx1, busy1;
    logic [7:0] din1;

    // FIFO model for dut0
    logic       push;
    logic [7:0] push_d;
    logic [7:0] fmem [4];
    logic [1:0] wp, rp;
    logic [2:0] cnt;

    // mailbox for dut1
    logic       mb_load;
    logic [7:0] mb_d;
    logic       mb_full;
    logic [7:0] mb_data;

    int tests = 0;
    int fails = 0;
    int pops0 = 0, pops1 = 0, badpop0 = 0, badpop1 = 0;

    always #5 clk = ~clk;

    fifo_uart_tx #(.WIDTH(8), .CLKS_PER_BIT(c_CPB), .PARITY(0), .STOP_BITS(1)) dut0 (
        .clk(clk), .rst(rst), .en(en), .empty(empty0), .datain(din0),
        .pop(pop0), .tx(tx0), .busy(busy0)
    );

    fifo_uart_tx #(.WIDTH(8), .CLKS_PER_BIT(c_CPB), .PARITY(1), .STOP_BITS(2)) dut1 (
        .clk(clk), .rst(rst), .en(en), .empty(empty1), .datain(din1),
        .pop(pop1), .tx(tx1), .busy(busy1)
    );

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            wp  <= 2'd0;
            rp  <= 2'd0;
            cnt <= 3'd0;
        end else begin
            if (push && cnt != 3'd4) begin
                fmem[wp] <= push_d;
                wp       <= wp + 2'd1;
            end
            if (pop0 && cnt != 3'd0) rp <= rp + 2'd1;
            cnt <= cnt + 3'(push && cnt != 3'd4) - 3'(pop0 && cnt != 3'd0);
        end
    end
    assign empty0 = (cnt == 3'd0);
    assign din0   = fmem[rp];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mb_full <= 1'b0;
            mb_data <= 8'h00;
        end else if (mb_load) begin
            mb_full <= 1'b1;
            mb_data <= mb_d;
        end else if (pop1) begin
            mb_full <= 1'b0;
        end
    end
    assign empty1 = ~mb_full;
    assign din1   = mb_data;

    always @(posedge clk) begin
        if (pop0) pops0 <= pops0 + 1;
        if (pop1) pops1 <= pops1 + 1;
        if (pop0 && empty0) badpop0 <= badpop0 + 1;
        if (pop1 && empty1) badpop1 <= badpop1 + 1;
    end

    typedef struct {
        bit          sel;    // 0 = dut0, 1 = dut1
        logic [7:0]  data;
        logic [11:0] frame;  // bit i = i-th serial bit on the line
        int          nbits;
    } vec_t;

    vec_t vecs [8];

    function automatic logic get_tx(input bit sel);
        return sel ? tx1 : tx0;
    endfunction

    function automatic logic get_busy(input bit sel);
        return sel ? busy1 : busy0;
    endfunction

    function automatic int get_pops(input bit sel);
        return sel ? pops1 : pops0;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_byte(input logic [7:0] d);
        push   = 1'b1;
        push_d = d;
        @(negedge clk);
        push   = 1'b0;
    endtask

    task automatic load_mb(input logic [7:0] d);
        mb_load = 1'b1;
        mb_d    = d;
        @(negedge clk);
        mb_load = 1'b0;
    endtask

    // Waits for the start bit, checks every cycle of the frame, then checks
    // the idle state one cycle after the last stop cycle and the pop count.
    task automatic check_frame(input bit sel, input logic [11:0] frame, input int nbits,
                               input string name, input int p0, output int wait_cyc);
        bit          found;
        bit          unstable;
        bit          busy_bad;
        logic [11:0] got;
        found    = 1'b0;
        wait_cyc = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            wait_cyc++;
            if (get_tx(sel) == 1'b0) begin
                found = 1'b1;
                break;
            end
        end
        chk({name, " start seen"}, 32'(found), 32'd1);
        if (found) begin
            unstable = 1'b0;
            busy_bad = 1'b0;
            got      = 12'h000;
            for (int c = 0; c < nbits * c_CPB; c++) begin
                if (c > 0) @(negedge clk);
                if (c % c_CPB == 0) got[c / c_CPB] = get_tx(sel);
                else if (get_tx(sel) !== got[c / c_CPB]) unstable = 1'b1;
                if (get_busy(sel) !== 1'b1) busy_bad = 1'b1;
            end
            chk({name, " bits"}, 32'(got), 32'(frame));
            chk({name, " bit hold"}, 32'(unstable), 32'd0);
            chk({name, " busy during frame"}, 32'(busy_bad), 32'd0);
            @(negedge clk);
            chk({name, " idle after frame {busy,tx}"}, 32'({get_busy(sel), get_tx(sel)}), 32'd1);
            chk({name, " pop count"}, 32'(get_pops(sel) - p0), 32'd1);
        end
    endtask

    // Watches n cycles: tx must stay high and no pop may occur on dut0
    task automatic watch_idle0(input string name, input int n);
        int p;
        bit low;
        p   = pops0;
        low = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (tx0 !== 1'b1) low = 1'b1;
        end
        chk({name, " tx stays high"}, 32'(low), 32'd0);
        chk({name, " no pop"}, 32'(pops0 - p), 32'd0);
    endtask

    initial begin
        int          p0;
        int          w;
        int          lat;
        bit          found;
        logic [11:0] f4 [4];

        vecs[0] = '{1'b0, 8'h5A, 12'b00_1010110100, 10};
        vecs[1] = '{1'b0, 8'hFF, 12'b00_1111111110, 10};
        vecs[2] = '{1'b0, 8'h00, 12'b00_1000000000, 10};
        vecs[3] = '{1'b0, 8'h81, 12'b00_1100000010, 10};
        vecs[4] = '{1'b1, 8'h07, {2'b11, 1'b1, 8'h07, 1'b0}, 12};
        vecs[5] = '{1'b1, 8'h03, {2'b11, 1'b0, 8'h03, 1'b0}, 12};
        vecs[6] = '{1'b1, 8'hA5, {2'b11, 1'b0, 8'hA5, 1'b0}, 12};
        vecs[7] = '{1'b1, 8'h80, {2'b11, 1'b1, 8'h80, 1'b0}, 12};

        rst     = 1'b1;
        en      = 1'b1;
        push    = 1'b0;
        push_d  = 8'h00;
        mb_load = 1'b0;
        mb_d    = 8'h00;

        @(negedge clk);
        chk("reset dut0 {tx,pop,busy}", 32'({tx0, pop0, busy0}), 32'b100);
        chk("reset dut1 {tx,pop,busy}", 32'({tx1, pop1, busy1}), 32'b100);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // Table-driven single frames
        for (int i = 0; i < 8; i++) begin
            if (!vecs[i].sel) begin
                p0 = pops0;
                push_byte(vecs[i].data);
            end else begin
                p0 = pops1;
                load_mb(vecs[i].data);
            end
            check_frame(vecs[i].sel, vecs[i].frame, vecs[i].nbits,
                        $sformatf("vec%0d", i), p0, w);
            repeat (4) @(negedge clk);
        end

        // Push into an empty FIFO while idle: the write lands, the next cycle
        // samples it, and FETCH follows, so pop appears 3 cycles after the push.
        repeat (5) @(negedge clk);
        p0     = pops0;
        push   = 1'b1;
        push_d = 8'h3C;
        lat    = 0;
        found  = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            push = 1'b0;
            lat++;
            if (pop0) begin
                found = 1'b1;
                break;
            end
        end
        chk("push-to-pop latency", 32'(lat), 32'd3);
        chk("push-to-pop data", 32'(din0), 32'h3C);
        check_frame(1'b0, {2'b00, 1'b1, 8'h3C, 1'b0}, 10, "fresh push", p0, w);

        // Four queued bytes, back-to-back frames with a 2-cycle gap
        en = 1'b0;
        repeat (2) @(negedge clk);
        push_byte(8'h11);
        push_byte(8'h22);
        push_byte(8'h33);
        push_byte(8'h44);
        f4[0] = {2'b00, 1'b1, 8'h11, 1'b0};
        f4[1] = {2'b00, 1'b1, 8'h22, 1'b0};
        f4[2] = {2'b00, 1'b1, 8'h33, 1'b0};
        f4[3] = {2'b00, 1'b1, 8'h44, 1'b0};
        en = 1'b1;
        for (int k = 0; k < 4; k++) begin
            p0 = pops0;
            check_frame(1'b0, f4[k], 10, $sformatf("burst%0d", k), p0, w);
            if (k > 0) chk($sformatf("burst%0d gap", k), 32'(w), 32'd2);
        end
        watch_idle0("after burst", 60);
        chk("after burst empty", 32'(empty0), 32'd1);

        // en low with data waiting, then en dropped mid-frame
        en = 1'b0;
        push_byte(8'hC3);
        watch_idle0("en low", 60);
        p0    = pops0;
        en    = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (pop0) begin
                found = 1'b1;
                break;
            end
        end
        chk("en rise pop seen", 32'(found), 32'd1);
        en = 1'b0;
        check_frame(1'b0, {2'b00, 1'b1, 8'hC3, 1'b0}, 10, "en dropped", p0, w);
        push_byte(8'h99);
        watch_idle0("en dropped hold", 50);
        p0 = pops0;
        en = 1'b1;
        check_frame(1'b0, {2'b00, 1'b1, 8'h99, 1'b0}, 10, "en resumed", p0, w);

        // Asynchronous reset in the middle of the data bits
        repeat (3) @(negedge clk);
        push_byte(8'hA5);
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (tx0 == 1'b0) begin
                found = 1'b1;
                break;
            end
        end
        chk("reset test start seen", 32'(found), 32'd1);
        repeat (10) @(negedge clk);
        chk("reset test busy mid-frame", 32'(busy0), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("async reset {tx,pop,busy}", 32'({tx0, pop0, busy0}), 32'b100);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        watch_idle0("after reset", 50);
        chk("after reset busy", 32'(busy0), 32'd0);

        chk("never popped empty", 32'(badpop0 + badpop1), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
